// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready request and response handshakes.
//   Single-cycle ops: ADD, SUB, AND, OR. MUL is iterative shift-add, one
//   multiplier bit per cycle. Illegal ops return result=0 with err=1.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   data0, data1, op    operands and opcode (0 ADD,1 SUB,2 AND,3 OR,4 MUL)
//   resp_valid/resp_ready response handshake
//   result, zero, err   response payload, stable while resp_valid=1
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [2:0]       op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplr, res_q;
  logic [WIDTH-1:0] acc_nxt, alu_res;
  logic [CNT_W-1:0] cnt;
  logic             err_q, alu_err;
  logic             accept, mul_last;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready;
  // The final iteration writes straight into the result register, so DONE is
  // entered on the WIDTH-th edge after accept.
  assign mul_last   = (cnt == CNT_W'(WIDTH - 1));
  assign result     = res_q;
  assign zero       = (res_q == '0);
  assign err        = err_q;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      3'd0:    alu_res = data0 + data1;
      3'd1:    alu_res = data0 - data1;
      3'd2:    alu_res = data0 & data1;
      3'd3:    alu_res = data0 | data1;
      3'd4:    alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    acc_nxt = mplr[0] ? acc + mcand : acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (op == 3'd4) ? MUL : DONE;
      MUL:     if (mul_last) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == 3'd4) begin
              acc   <= '0;
              cnt   <= '0;
              mcand <= data0;
              mplr  <= data1;
              err_q <= 1'b0;
            end else begin
              res_q <= alu_res;
              err_q <= alu_err;
            end
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (mul_last) res_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Expected responses are
// queued when a request is issued and compared when the response handshake
// occurs; latency and backpressure/reset behaviour are checked inline.
module tb_seq_alu;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic [2:0]   op = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  int    n_checks = 0;
  int    n_fail = 0;
  resp_t sb[$];

  seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .data0     (data0),
    .data1     (data1),
    .op        (op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic resp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    resp_t r;
    logic [2*W-1:0] p;
    r.err = 1'b0;
    case (o)
      3'd0: r.res = a + b;
      3'd1: r.res = a - b;
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.res = p[W-1:0];
      end
      default: begin
        r.res = '0;
        r.err = 1'b1;
      end
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  // Response monitor: the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("stale_resp", 1, 0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero", zero, e.zero);
        check("err", err, e.err);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_ready_timeout", req_ready, 1);
  endtask

  // Issue one request, check latency to resp_valid; if resp_ready is high the
  // task also waits out the response handshake.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_lat);
    int lat;
    wait_ready();
    sb.push_back(model(o, a, b));
    data0 = a; data1 = b; op = o; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    data0 = $urandom; data1 = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t e;
    int    seen;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_err", err, 0);

    issue(3'd0, 32'd123, 32'd456, 1);
    issue(3'd1, 32'd123, 32'd456, 1);
    issue(3'd2, 32'd123, 32'd456, 1);
    issue(3'd3, 32'd123, 32'd456, 1);
    issue(3'd4, 32'd123, 32'd456, W + 1);
    issue(3'd4, 32'hFFFF_FFFF, 32'd2, W + 1);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, W + 1);
    issue(3'd6, 32'd5, 32'd7, 1);
    issue(3'd0, 32'd0, 32'd0, 1);
    issue(3'd1, 32'd77, 32'd77, 1);

    // Backpressure: hold the response, keep a second request pending.
    resp_ready = 1'b0;
    e = model(3'd1, 32'd1000, 32'd1);
    issue(3'd1, 32'd1000, 32'd1, 1);
    data0 = 32'd6; data1 = 32'd7; op = 3'd4; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", result, e.res);
      check("bp_req_ready", req_ready, 0);
      check("bp_resp_valid", resp_valid, 1);
    end
    sb.push_back(model(3'd4, 32'd6, 32'd7));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_accepted", req_ready, 0);
    seen = 0;
    while (!resp_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    check("bp_second_latency", seen + 1, W + 1);
    @(posedge clk); #1;

    // Reset during MUL, after 10 iterations.
    wait_ready();
    data0 = 32'd99; data1 = 32'd99; op = 3'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_result", result, 0);
    seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);

    // Random mix of all opcodes.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 3)) : $urandom;
      issue(o, a, b, (o == 3'd4) ? W + 1 : 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
